switch_event_capture: RTL and testbench
=======================================

Name: switch_event_capture

Overview:
- Control-side receiver for the debounced switch interface: consumes the debounced level and its ready strobe, and turns transitions into discrete, acknowledged events for the control FSM.
- Events are PRESS, RELEASE and LONG (held ≥ LONG_CYCLES).
- One-deep event register with valid/ack handshake and a sticky overflow flag.
- Sits between each debouncer instance and the system controller.

Parameters:
- LONG_N, 26, width of hold counter.
- LONG_CYCLES, 50_000_000, clk cycles of continuous press before LONG fires (1 s at 20 ns period). Must satisfy 2 ≤ LONG_CYCLES < 2^LONG_N.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- level_in  in  1  debounced switch level from debouncer
- ready_in  in  1  debouncer ready strobe; may be high one or more cycles
- evt_ack  in  1  controller accepts pending event
- clr_ovf  in  1  clears overflow flag
- evt_valid  out  1  event pending
- evt_code  out  2  00 none, 01 PRESS, 10 RELEASE, 11 LONG
- pressed  out  1  registered accepted switch state
- overflow  out  1  sticky: event dropped while one was pending

Behaviour:
- Reset (rst=0, async) sets all of the following:
  - state = IDLE
  - pressed = 0, counter = 0
  - evt_valid = 0, evt_code = 00, overflow = 0
- Accept condition: ready_in=1 AND level_in != pressed. Strobe with level_in == pressed is ignored, so multi-cycle strobes yield exactly one event. level_in is ignored while ready_in=0.
- FSM states:
  - IDLE: on accept with level_in=1 → PRESSED, pressed←1, counter←0, raise PRESS.
  - PRESSED: counter increments each cycle. On accept (level_in=0) → IDLE, pressed←0, counter←0, raise RELEASE. Else if counter == LONG_CYCLES-1 → HELD, raise LONG, counter frozen.
  - HELD: on accept (level_in=0) → IDLE, pressed←0, counter←0, raise RELEASE. No further LONG until a new press.
- Release and timeout in the same cycle: release wins; no LONG is raised.
- Timing: all outputs are registered.
  - An event raised at edge k shows evt_valid=1 with its code after edge k (zero added latency from the accepting edge).
  - LONG appears exactly LONG_CYCLES edges after the PRESS edge.
- Handshake:
  - evt_valid/evt_code hold until a cycle with evt_ack=1 while evt_valid=1. That edge clears evt_valid, and evt_code←00.
  - evt_ack while evt_valid=0 has no effect.
- Collision handling:
  - New event while evt_valid=1 and evt_ack=0: the new event is dropped, the pending one is kept, overflow←1.
  - The FSM and pressed still advance normally when an event is dropped.
  - New event and evt_ack in the same cycle: the new event is loaded, evt_valid stays 1, no overflow.
- Overflow: sticky; cleared by clr_ovf=1. If set and cleared in the same cycle, set wins.
- Counter never wraps: it only counts in PRESSED and stops at LONG_CYCLES-1.
- Reset mid-operation (any state, pending event): everything returns to reset values immediately. No event is emitted on deassertion even if level_in=1; the next strobe with level_in=1 produces PRESS.

Test Plan:
- Reset, LONG_CYCLES=8, then ready_in pulse 1 cycle with level_in=1 → evt_valid=1, evt_code=01, pressed=1 after that edge; ack next cycle → evt_valid=0, code=00.
- Press (acked), hold 8 cycles with no strobe → evt_code=11 exactly 8 edges after the PRESS edge. Ack, then strobe level_in=0 → evt_code=10, pressed=0.
- ready_in held high 5 cycles with level_in=1 → exactly one PRESS; overflow stays 0.
- PRESS not acked, then release strobe → evt_code stays 01, overflow=1, pressed=0. Pulse clr_ovf → overflow=0.
- PRESS pending; release strobe in the same cycle as evt_ack → evt_code=10, evt_valid=1, overflow=0. Release strobe at counter==7 (LONG_CYCLES-1) → RELEASE only, never 11.
- In HELD with evt_valid=1, drive rst=0 mid-cycle → all outputs 0 asynchronously. Release rst with level_in=1, no strobe → no event. Then strobe → PRESS.

Source files
------------

// File: rtl/switch_event_capture.sv
// Turns debounced switch transitions into PRESS / RELEASE / LONG events held
// in a one-deep register with a valid/ack handshake and a sticky overflow flag.
module switch_event_capture #(
    parameter int LONG_N      = 26,
    parameter int LONG_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_in,
    input  logic       ready_in,
    input  logic       evt_ack,
    input  logic       clr_ovf,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       pressed,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_PRESS   = 2'b01;
    localparam logic [1:0] CODE_RELEASE = 2'b10;
    localparam logic [1:0] CODE_LONG    = 2'b11;

    localparam logic [LONG_N-1:0] CNT_LAST = LONG_N'(LONG_CYCLES - 1);

    state_t            state_q, state_d;
    logic              pressed_q, pressed_d;
    logic [LONG_N-1:0] cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [1:0]        code_q, code_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              raise;
    logic [1:0]        raise_code;

    // Strobes that repeat the current level are ignored, so a long strobe yields one event.
    assign accept = ready_in && (level_in != pressed_q);

    always_comb begin
        state_d    = state_q;
        pressed_d  = pressed_q;
        cnt_d      = cnt_q;
        raise      = 1'b0;
        raise_code = CODE_NONE;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = PRESSED;
                    pressed_d  = 1'b1;
                    cnt_d      = '0;
                    raise      = 1'b1;
                    raise_code = CODE_PRESS;
                end
            end
            PRESSED: begin
                // Release takes priority over a coincident timeout.
                if (accept) begin
                    state_d    = IDLE;
                    pressed_d  = 1'b0;
                    cnt_d      = '0;
                    raise      = 1'b1;
                    raise_code = CODE_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = HELD;
                    raise      = 1'b1;
                    raise_code = CODE_LONG;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (accept) begin
                    state_d    = IDLE;
                    pressed_d  = 1'b0;
                    cnt_d      = '0;
                    raise      = 1'b1;
                    raise_code = CODE_RELEASE;
                end
            end
            default: begin
                state_d   = IDLE;
                pressed_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovf_d   = ovf_q & ~clr_ovf;
        if (raise) begin
            // An ack in the same cycle frees the slot for the new event.
            if (!valid_q || evt_ack) begin
                valid_d = 1'b1;
                code_d  = raise_code;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && evt_ack) begin
            valid_d = 1'b0;
            code_d  = CODE_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            code_q    <= CODE_NONE;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            ovf_q     <= ovf_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_code  = code_q;
    assign pressed   = pressed_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_switch_event_capture.sv
// Directed bench for switch_event_capture with LONG_CYCLES = 8.
module tb_switch_event_capture;

    logic       clk;
    logic       rst;
    logic       level_in;
    logic       ready_in;
    logic       evt_ack;
    logic       clr_ovf;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       pressed;
    logic       overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    switch_event_capture #(
        .LONG_N     (4),
        .LONG_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .level_in (level_in),
        .ready_in (ready_in),
        .evt_ack  (evt_ack),
        .clr_ovf  (clr_ovf),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .pressed  (pressed),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-20s observed=%0d expected=%0d ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks valid, code, pressed, overflow together.
    task automatic chk_all(input string tag, input logic v, input logic [1:0] c,
                           input logic p, input logic o);
        chk({tag, ".valid"}, {1'b0, evt_valid}, {1'b0, v});
        chk({tag, ".code"},  evt_code,          c);
        chk({tag, ".press"}, {1'b0, pressed},   {1'b0, p});
        chk({tag, ".ovf"},   {1'b0, overflow},  {1'b0, o});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; level_in = 1'b0; ready_in = 1'b0; evt_ack = 1'b0; clr_ovf = 1'b0;
        #1;
        chk_all("reset", 1'b0, 2'b00, 1'b0, 1'b0);
        step(2);
        rst = 1'b1;
        step(1);
        chk_all("idle", 1'b0, 2'b00, 1'b0, 1'b0);

        // Press, ack, then LONG exactly 8 edges after the press edge.
        ready_in = 1'b1; level_in = 1'b1;
        step(1);
        chk_all("press", 1'b1, 2'b01, 1'b1, 1'b0);
        ready_in = 1'b0; evt_ack = 1'b1;
        step(1);
        chk_all("press_ack", 1'b0, 2'b00, 1'b1, 1'b0);
        evt_ack = 1'b0;
        step(6);
        chk_all("pre_long", 1'b0, 2'b00, 1'b1, 1'b0);
        step(1);
        chk_all("long", 1'b1, 2'b11, 1'b1, 1'b0);
        evt_ack = 1'b1;
        step(1);
        chk_all("long_ack", 1'b0, 2'b00, 1'b1, 1'b0);
        evt_ack = 1'b0;
        step(3);
        chk_all("held_no_relong", 1'b0, 2'b00, 1'b1, 1'b0);
        ready_in = 1'b1; level_in = 1'b0;
        step(1);
        chk_all("release", 1'b1, 2'b10, 1'b0, 1'b0);
        ready_in = 1'b0; evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
        chk_all("release_ack", 1'b0, 2'b00, 1'b0, 1'b0);

        // Multi-cycle strobe gives a single PRESS; unacked release overflows.
        ready_in = 1'b1; level_in = 1'b1;
        step(5);
        chk_all("long_strobe", 1'b1, 2'b01, 1'b1, 1'b0);
        level_in = 1'b0;
        step(1);
        chk_all("drop_release", 1'b1, 2'b01, 1'b0, 1'b1);
        ready_in = 1'b0; clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk_all("clr_ovf", 1'b1, 2'b01, 1'b0, 1'b0);
        evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
        chk_all("ack2", 1'b0, 2'b00, 1'b0, 1'b0);

        // Release strobe coincident with ack replaces the pending PRESS.
        ready_in = 1'b1; level_in = 1'b1;
        step(1);
        chk_all("press3", 1'b1, 2'b01, 1'b1, 1'b0);
        level_in = 1'b0; evt_ack = 1'b1;
        step(1);
        chk_all("rel_with_ack", 1'b1, 2'b10, 1'b0, 1'b0);
        ready_in = 1'b0;
        step(1);
        evt_ack = 1'b0;
        chk_all("ack3", 1'b0, 2'b00, 1'b0, 1'b0);

        // Release exactly at counter == LONG_CYCLES-1: RELEASE only.
        ready_in = 1'b1; level_in = 1'b1;
        step(1);
        ready_in = 1'b0; evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
        step(6);
        chk_all("cnt7", 1'b0, 2'b00, 1'b1, 1'b0);
        ready_in = 1'b1; level_in = 1'b0;
        step(1);
        chk_all("rel_at_timeout", 1'b1, 2'b10, 1'b0, 1'b0);
        ready_in = 1'b0;
        step(3);
        chk_all("no_late_long", 1'b1, 2'b10, 1'b0, 1'b0);
        evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;

        // Async reset while HELD with LONG pending.
        ready_in = 1'b1; level_in = 1'b1;
        step(1);
        ready_in = 1'b0; evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
        step(7);
        chk_all("long2", 1'b1, 2'b11, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 2'b00, 1'b0, 1'b0);
        step(1);
        rst = 1'b1;
        step(3);
        chk_all("post_rst_quiet", 1'b0, 2'b00, 1'b0, 1'b0);
        ready_in = 1'b1;
        step(1);
        ready_in = 1'b0;
        chk_all("post_rst_press", 1'b1, 2'b01, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
